// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// ram_arbiter_pkg : shared types and helpers for the three-master RAM arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_RESP   = 2'd2
  } arb_state_e;

  // Grant index meaning "no owner"
  localparam logic [1:0] GNT_NONE = 2'd3;

  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr_pick3.sv
// ============================================================================
// ram_arbiter_rr_pick3 : combinational round-robin winner select, optional m0 priority
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_arbiter_rr_pick3
  import ram_arbiter_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic       m0_prio_i,
  output logic       valid_o,
  output logic [1:0] idx_o
);

  logic [1:0] cand;

  always_comb begin
    valid_o = |req_i;
    idx_o   = GNT_NONE;
    cand    = ptr_i;
    // Scan ptr, ptr+1, ptr+2 (wrapping) and keep the first requester found
    for (int k = 0; k < 3; k++) begin
      if ((idx_o == GNT_NONE) && req_i[cand]) begin
        idx_o = cand;
      end
      cand = inc_mod3(cand);
    end
    if (m0_prio_i && req_i[0]) begin
      idx_o = 2'd0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// ram_arbiter : shares a single-port RAM between three masters, one access per grant
// Revision 1.0
// ============================================================================
`default_nettype none

module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter bit M0_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req_i,
  input  logic              m0_we_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  input  logic              m1_req_i,
  input  logic              m1_we_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  input  logic              m2_req_i,
  input  logic              m2_we_i,
  input  logic [ADDR_W-1:0] m2_addr_i,
  input  logic [DATA_W-1:0] m2_data_i,
  output logic [DATA_W-1:0] m2_data_o,
  output logic              m2_ack_o,
  output logic              s_req_o,
  output logic              s_we_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [DATA_W-1:0] s_data_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic [1:0]        gnt_o
);

  arb_state_e        state_q, state_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        ptr_q, ptr_d;
  logic [DATA_W-1:0] rdata_q [3];
  logic              cap_en;

  logic [2:0]        req_w;
  logic [2:0]        we_w;
  logic [ADDR_W-1:0] addr_w  [3];
  logic [DATA_W-1:0] wdata_w [3];
  logic              pick_valid;
  logic [1:0]        pick_idx;

  assign req_w      = {m2_req_i, m1_req_i, m0_req_i};
  assign we_w       = {m2_we_i, m1_we_i, m0_we_i};
  assign addr_w[0]  = m0_addr_i;
  assign addr_w[1]  = m1_addr_i;
  assign addr_w[2]  = m2_addr_i;
  assign wdata_w[0] = m0_data_i;
  assign wdata_w[1] = m1_data_i;
  assign wdata_w[2] = m2_data_i;

  ram_arbiter_rr_pick3 u_pick (
    .req_i     (req_w),
    .ptr_i     (ptr_q),
    .m0_prio_i (M0_PRIO),
    .valid_o   (pick_valid),
    .idx_o     (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      gnt_q   <= GNT_NONE;
      ptr_q   <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        rdata_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      if (cap_en) begin
        rdata_q[gnt_q] <= s_data_i;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    ptr_d    = ptr_q;
    cap_en   = 1'b0;
    s_req_o  = 1'b0;
    s_we_o   = 1'b0;
    s_addr_o = '0;
    s_data_o = '0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          state_d = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (req_w[gnt_q]) begin
          s_req_o  = 1'b1;
          s_we_o   = we_w[gnt_q];
          s_addr_o = addr_w[gnt_q];
          s_data_o = wdata_w[gnt_q];
          cap_en   = ~we_w[gnt_q];
          state_d  = ARB_RESP;
        end else begin
          gnt_d   = GNT_NONE;
          state_d = ARB_IDLE;
        end
      end
      ARB_RESP: begin
        ptr_d   = inc_mod3(gnt_q);
        gnt_d   = GNT_NONE;
        state_d = ARB_IDLE;
      end
      default: begin
        gnt_d   = GNT_NONE;
        state_d = ARB_IDLE;
      end
    endcase
    // A reset landing on the closing edge of an access must not commit the write
    if (rst) begin
      s_req_o = 1'b0;
      s_we_o  = 1'b0;
    end
  end

  assign gnt_o     = gnt_q;
  assign m0_ack_o  = (state_q == ARB_RESP) && (gnt_q == 2'd0);
  assign m1_ack_o  = (state_q == ARB_RESP) && (gnt_q == 2'd1);
  assign m2_ack_o  = (state_q == ARB_RESP) && (gnt_q == 2'd2);
  assign m0_data_o = rdata_q[0];
  assign m1_data_o = rdata_q[1];
  assign m2_data_o = rdata_q[2];

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// tb_ram_arbiter : scoreboard bench; dut 0 is plain round-robin, dut 1 has m0 priority
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

  typedef struct {
    int          m;
    bit          we;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  logic        req   [2][3];
  logic        we    [2][3];
  logic [31:0] addr  [2][3];
  logic [31:0] wd    [2][3];
  logic [31:0] rd    [2][3];
  logic        ack   [2][3];
  logic [1:0]  gnt   [2];
  logic        sreq  [2];
  logic        swe   [2];
  logic [31:0] saddr [2];
  logic [31:0] sdo   [2];
  logic [31:0] sdi   [2];
  logic [31:0] mem   [2][256];

  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar d = 0; d < 2; d++) begin : g_dut
    ram_arbiter #(.ADDR_W(32), .DATA_W(32), .M0_PRIO(d == 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .m0_req_i  (req[d][0]),
      .m0_we_i   (we[d][0]),
      .m0_addr_i (addr[d][0]),
      .m0_data_i (wd[d][0]),
      .m0_data_o (rd[d][0]),
      .m0_ack_o  (ack[d][0]),
      .m1_req_i  (req[d][1]),
      .m1_we_i   (we[d][1]),
      .m1_addr_i (addr[d][1]),
      .m1_data_i (wd[d][1]),
      .m1_data_o (rd[d][1]),
      .m1_ack_o  (ack[d][1]),
      .m2_req_i  (req[d][2]),
      .m2_we_i   (we[d][2]),
      .m2_addr_i (addr[d][2]),
      .m2_data_i (wd[d][2]),
      .m2_data_o (rd[d][2]),
      .m2_ack_o  (ack[d][2]),
      .s_req_o   (sreq[d]),
      .s_we_o    (swe[d]),
      .s_addr_o  (saddr[d]),
      .s_data_o  (sdo[d]),
      .s_data_i  (sdi[d]),
      .gnt_o     (gnt[d])
    );
  end

  // RAM models: combinational read, write on the closing edge
  always_comb begin
    for (int d = 0; d < 2; d++) sdi[d] = mem[d][saddr[d][9:2]];
  end
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++)
      if (sreq[d] && swe[d]) mem[d][saddr[d][9:2]] <= sdo[d];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int d, input int m, input bit w, input logic [31:0] data, input int c);
    exp_t e;
    e = '{m, w, data, c};
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic mon(input int d);
    int   na;
    int   m;
    exp_t e;
    na = 0;
    m  = 0;
    for (int k = 0; k < 3; k++) begin
      if (ack[d][k] === 1'b1) begin
        na++;
        m = k;
      end
    end
    if (na > 0) begin
      chk($sformatf("dut%0d_acks_per_cycle", d), na, 1);
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        checks++;
        failures++;
        $display("FAIL dut%0d_unexpected_ack actual=m%0d required=none (cycle %0d)", d, m, cyc);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk($sformatf("dut%0d_ack_master", d), m, e.m);
        chk($sformatf("dut%0d_ack_cycle", d), cyc, e.cyc);
        if (!e.we) chk($sformatf("dut%0d_rdata_m%0d", d, m), rd[d][m], e.data);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic at_pos(input int c);
    int g;
    g = 0;
    @(posedge clk); #1;
    while (cyc < c && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    if (cyc != c) begin
      checks++;
      failures++;
      $display("FAIL sched_pos actual=%0d required=%0d", cyc, c);
    end
  endtask

  task automatic at_neg(input int c);
    int g;
    g = 0;
    @(negedge clk);
    while (cyc < c && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (cyc != c) begin
      checks++;
      failures++;
      $display("FAIL sched_neg actual=%0d required=%0d", cyc, c);
    end
  endtask

  task automatic drive(input int d, input int m, input bit w, input logic [31:0] a, input logic [31:0] data);
    req[d][m]  = 1'b1;
    we[d][m]   = w;
    addr[d][m] = a;
    wd[d][m]   = data;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic chk_idle_outputs(input int d, input string tag);
    chk({tag, "_gnt"}, gnt[d], 2'd3);
    chk({tag, "_s_req"}, sreq[d], 1'b0);
    chk({tag, "_s_we"}, swe[d], 1'b0);
    chk({tag, "_s_addr"}, saddr[d], 32'h0);
    chk({tag, "_s_data"}, sdo[d], 32'h0);
    for (int m = 0; m < 3; m++) begin
      chk($sformatf("%s_ack%0d", tag, m), ack[d][m], 1'b0);
      chk($sformatf("%s_data_o%0d", tag, m), rd[d][m], 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int n2;
    int n3;
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      for (int m = 0; m < 3; m++) begin
        req[d][m] = 1'b0; we[d][m] = 1'b0; addr[d][m] = '0; wd[d][m] = '0;
      end
      for (int i = 0; i < 256; i++) mem[d][i] <= '0;
    end
    mem[0][4]   <= 32'hA0A0_0000;
    mem[0][5]   <= 32'hA1A1_1111;
    mem[0][6]   <= 32'hA2A2_2222;
    mem[0][16]  <= 32'h0000_0011;
    mem[0][32]  <= 32'h0000_0033;
    mem[0][128] <= 32'h5A5A_5A5A;
    mem[1][8]   <= 32'hB1B1_0001;
    mem[1][9]   <= 32'hB2B2_0002;
    mem[1][12]  <= 32'hC0C0_0000;

    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_idle_outputs(0, "rst_dut0");
    chk_idle_outputs(1, "rst_dut1");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single write then read-back by m1
    n = cyc;
    drive(0, 1, 1'b1, 32'h100, 32'hDEAD_BEEF);
    push(0, 1, 1'b1, 32'h0, n + 2);
    at_neg(n + 1);
    chk("t1_access_s_req", sreq[0], 1'b1);
    chk("t1_access_s_we", swe[0], 1'b1);
    chk("t1_access_s_addr", saddr[0], 32'h100);
    chk("t1_access_s_data", sdo[0], 32'hDEAD_BEEF);
    chk("t1_access_gnt", gnt[0], 2'd1);
    at_neg(n + 2);
    req[0][1] = 1'b0;
    at_pos(n + 3);
    chk("t1_ram_written", mem[0][64], 32'hDEAD_BEEF);
    n = cyc;
    drive(0, 1, 1'b0, 32'h100, 32'h0);
    push(0, 1, 1'b0, 32'hDEAD_BEEF, n + 2);
    at_neg(n + 1);
    chk("t1_read_s_we", swe[0], 1'b0);
    at_neg(n + 2);
    req[0][1] = 1'b0;
    at_pos(n + 3);

    // All three held, plain round-robin from ptr 0
    do_reset();
    n = cyc;
    drive(0, 0, 1'b0, 32'h10, 32'h0);
    drive(0, 1, 1'b0, 32'h14, 32'h0);
    drive(0, 2, 1'b0, 32'h18, 32'h0);
    push(0, 0, 1'b0, 32'hA0A0_0000, n + 2);
    push(0, 1, 1'b0, 32'hA1A1_1111, n + 5);
    push(0, 2, 1'b0, 32'hA2A2_2222, n + 8);
    push(0, 0, 1'b0, 32'hA0A0_0000, n + 11);
    at_neg(n + 11);
    req[0][0] = 1'b0; req[0][1] = 1'b0; req[0][2] = 1'b0;
    at_pos(n + 12);

    // m0 priority: m1/m2 held, m0 pulses in and jumps the queue
    do_reset();
    n = cyc;
    drive(1, 1, 1'b0, 32'h20, 32'h0);
    drive(1, 2, 1'b0, 32'h24, 32'h0);
    push(1, 1, 1'b0, 32'hB1B1_0001, n + 2);
    at_pos(n + 1);
    drive(1, 0, 1'b0, 32'h30, 32'h0);
    push(1, 0, 1'b0, 32'hC0C0_0000, n + 5);
    push(1, 1, 1'b0, 32'hB1B1_0001, n + 8);
    push(1, 2, 1'b0, 32'hB2B2_0002, n + 11);
    at_neg(n + 5);
    req[1][0] = 1'b0;
    at_neg(n + 11);
    req[1][1] = 1'b0; req[1][2] = 1'b0;
    at_pos(n + 12);

    // m2 abandons a write during ACCESS
    n = cyc;
    drive(0, 2, 1'b1, 32'h40, 32'h0000_0022);
    at_pos(n + 1);
    req[0][2] = 1'b0;
    at_neg(n + 1);
    chk("t4_abort_s_req", sreq[0], 1'b0);
    chk("t4_abort_s_we", swe[0], 1'b0);
    at_neg(n + 2);
    chk("t4_back_idle_gnt", gnt[0], 2'd3);
    chk("t4_no_ack", ack[0][2], 1'b0);
    at_pos(n + 3);
    chk("t4_ram_unchanged", mem[0][16], 32'h0000_0011);

    // Reset lands during an m1 write access
    n = cyc;
    drive(0, 1, 1'b1, 32'h80, 32'h0000_0044);
    at_pos(n + 1);
    rst = 1'b1;
    at_neg(n + 1);
    chk("t5_rst_s_we", swe[0], 1'b0);
    at_pos(n + 2);
    rst = 1'b0;
    req[0][1] = 1'b0;
    at_neg(n + 2);
    chk_idle_outputs(0, "t5_after_rst");
    chk("t5_ram_unchanged", mem[0][32], 32'h0000_0033);

    // After reset ptr is 0 (m0 wins), then m1; m0 write must not touch m0_data_o
    n2 = n + 3;
    at_pos(n2);
    drive(0, 0, 1'b0, 32'h200, 32'h0);
    drive(0, 1, 1'b0, 32'h14, 32'h0);
    drive(0, 2, 1'b0, 32'h18, 32'h0);
    push(0, 0, 1'b0, 32'h5A5A_5A5A, n2 + 2);
    push(0, 1, 1'b0, 32'hA1A1_1111, n2 + 5);
    at_neg(n2 + 2);
    req[0][0] = 1'b0;
    at_neg(n2 + 5);
    req[0][1] = 1'b0; req[0][2] = 1'b0;
    at_pos(n2 + 6);
    n3 = cyc;
    drive(0, 0, 1'b1, 32'h200, 32'h0BAD_F00D);
    push(0, 0, 1'b1, 32'h0, n3 + 2);
    at_neg(n3 + 2);
    req[0][0] = 1'b0;
    chk("t6_data_o_during_write_ack", rd[0][0], 32'h5A5A_5A5A);
    at_neg(n3 + 3);
    chk("t6_data_o_after_write", rd[0][0], 32'h5A5A_5A5A);
    chk("t6_ram_written", mem[0][128], 32'h0BAD_F00D);

    at_pos(n3 + 6);
    chk("dut0_pending_expectations", q0.size(), 0);
    chk("dut1_pending_expectations", q1.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
